// File: rtl/dpram_rr_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter: request handshake plus read responses.
interface dpram_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [DATA_W-1:0]         rsp_data_b;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_data_b
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_data_b
    );
endinterface

// File: rtl/dpram_rr_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto the two ports of a
// 16x8 dual-port RAM, serialising same-address hazards and routing read data back.
module dpram_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dpram_rr_arbiter_if.slave bus,
    output logic              ram_we_a,
    output logic              ram_we_b,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_din_a,
    output logic [DATA_W-1:0] ram_din_b,
    input  logic [DATA_W-1:0] ram_dout_a,
    input  logic [DATA_W-1:0] ram_dout_b,
    output logic [7:0]        conflict_cnt
);
    localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    logic [ADDR_W-1:0]  addr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata [NUM_REQ];
    logic [NUM_REQ-1:0] valid_m;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] rsp_next;

    idx_t ptr, ptr_next;
    idx_t g0, g1;
    idx_t scan_idx;
    int   scan_sum;
    logic has_g0, cand_ok, has_g1, conflict;

    idx_t own_a, own_b;
    logic rd_a, rd_b;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_b_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
        assign wdata[i] = bus.req_wdata[i*DATA_W +: DATA_W];
    end

    // Masking with rst_n keeps every grant, ready and RAM strobe low while reset is held.
    assign valid_m = bus.req_valid & {NUM_REQ{rst_n}};

    function automatic idx_t wrap_inc(input idx_t v);
        return (int'(v) == NUM_REQ - 1) ? '0 : idx_t'(v + 1'b1);
    endfunction

    // Scan one full rotation from ptr: first hit is g0, second hit is the port B candidate.
    always_comb begin
        has_g0   = 1'b0;
        cand_ok  = 1'b0;
        g0       = '0;
        g1       = '0;
        scan_sum = 0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = int'(ptr) + k;
            if (scan_sum >= NUM_REQ) scan_sum = scan_sum - NUM_REQ;
            scan_idx = scan_sum[IDX_W-1:0];
            if (valid_m[scan_idx]) begin
                if (!has_g0) begin
                    has_g0 = 1'b1;
                    g0     = scan_idx;
                end else if (!cand_ok) begin
                    cand_ok = 1'b1;
                    g1      = scan_idx;
                end
            end
        end
        conflict = cand_ok && (addr[g0] == addr[g1]) &&
                   (bus.req_we[g0] || bus.req_we[g1]);
        has_g1   = cand_ok && !conflict;
    end

    always_comb begin
        ready = '0;
        if (has_g0) ready[g0] = 1'b1;
        if (has_g1) ready[g1] = 1'b1;

        ram_we_a   = has_g0 && bus.req_we[g0];
        ram_addr_a = has_g0 ? addr[g0]  : '0;
        ram_din_a  = has_g0 ? wdata[g0] : '0;
        ram_we_b   = has_g1 && bus.req_we[g1];
        ram_addr_b = has_g1 ? addr[g1]  : '0;
        ram_din_b  = has_g1 ? wdata[g1] : '0;

        if (has_g1)      ptr_next = wrap_inc(g1);
        else if (has_g0) ptr_next = wrap_inc(g0);
        else             ptr_next = ptr;
    end

    always_comb begin
        rsp_next = '0;
        if (rd_a) rsp_next[own_a] = 1'b1;
        if (rd_b) rsp_next[own_b] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            conflict_cnt <= '0;
            rd_a         <= 1'b0;
            rd_b         <= 1'b0;
            own_a        <= '0;
            own_b        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_data_b_q <= '0;
        end else begin
            ptr <= ptr_next;
            if (conflict && (conflict_cnt != 8'hFF)) conflict_cnt <= conflict_cnt + 8'd1;
            rd_a  <= has_g0 && !bus.req_we[g0];
            own_a <= g0;
            rd_b  <= has_g1 && !bus.req_we[g1];
            own_b <= g1;
            // RAM dout is valid the cycle after the address, i.e. while rd_a/rd_b are set.
            rsp_valid_q <= rsp_next;
            if (rd_a) rsp_data_q   <= ram_dout_a;
            if (rd_b) rsp_data_b_q <= ram_dout_b;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_data_b = rsp_data_b_q;

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Bench for dpram_rr_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference of the rotation, hazard and response rules, with a behavioural RAM.
module tb_dpram_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    dpram_rr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic          ram_we_a, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a, ram_din_b;
    logic [DW-1:0] ram_dout_a, ram_dout_b;
    logic [7:0]    conflict_cnt;

    dpram_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .ram_we_a     (ram_we_a),
        .ram_we_b     (ram_we_b),
        .ram_addr_a   (ram_addr_a),
        .ram_addr_b   (ram_addr_b),
        .ram_din_a    (ram_din_a),
        .ram_din_b    (ram_din_b),
        .ram_dout_a   (ram_dout_a),
        .ram_dout_b   (ram_dout_b),
        .conflict_cnt (conflict_cnt)
    );

    // Behavioural 16x8 dual-port RAM with registered read outputs.
    logic [DW-1:0] ram [16] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
        if (ram_we_b) ram[ram_addr_b] <= ram_din_b;
        ram_dout_a <= ram[ram_addr_a];
        ram_dout_b <= ram[ram_addr_b];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_ptr, m_cnt, m_g0, m_g1;
    bit            m_conf;
    logic [DW-1:0] m_mem [16];
    logic [N-1:0]  e_ready;
    logic          e_we_a, e_we_b;
    logic [AW-1:0] e_addr_a, e_addr_b;
    logic [DW-1:0] e_din_a, e_din_b;
    logic [N-1:0]  q1_v, q2_v;
    bit            q1_a, q1_b, q2_a, q2_b;
    logic [DW-1:0] q1_da, q1_db, q2_da, q2_db;

    function automatic logic [AW-1:0] rq_addr(input int i);
        return bus.req_addr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] rq_data(input int i);
        return bus.req_wdata[i*DW +: DW];
    endfunction

    task automatic set_req(input int i, input bit v, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]         = v;
        bus.req_we[i]            = we;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_g0 = -1; m_g1 = -1; m_conf = 1'b0;
        q1_v = '0; q2_v = '0; q1_a = 0; q1_b = 0; q2_a = 0; q2_b = 0;
        q1_da = '0; q1_db = '0; q2_da = '0; q2_db = '0;
    endtask

    task automatic model_eval();
        int order[$];
        int cand;
        for (int k = 0; k < N; k++)
            if (bus.req_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
        m_g0   = (order.size() > 0) ? order[0] : -1;
        cand   = (order.size() > 1) ? order[1] : -1;
        m_conf = (cand >= 0) && (rq_addr(m_g0) == rq_addr(cand)) &&
                 (bus.req_we[m_g0] || bus.req_we[cand]);
        m_g1   = m_conf ? -1 : cand;
        e_ready = '0;
        if (m_g0 >= 0) e_ready[m_g0] = 1'b1;
        if (m_g1 >= 0) e_ready[m_g1] = 1'b1;
        e_we_a   = (m_g0 >= 0) && bus.req_we[m_g0];
        e_addr_a = (m_g0 >= 0) ? rq_addr(m_g0) : '0;
        e_din_a  = (m_g0 >= 0) ? rq_data(m_g0) : '0;
        e_we_b   = (m_g1 >= 0) && bus.req_we[m_g1];
        e_addr_b = (m_g1 >= 0) ? rq_addr(m_g1) : '0;
        e_din_b  = (m_g1 >= 0) ? rq_data(m_g1) : '0;
    endtask

    task automatic model_commit();
        logic [N-1:0]  nv = '0;
        bit            na = 0, nb = 0;
        logic [DW-1:0] nda = '0, ndb = '0;
        if (m_g0 >= 0 && !bus.req_we[m_g0]) begin nv[m_g0] = 1; na = 1; nda = m_mem[rq_addr(m_g0)]; end
        if (m_g1 >= 0 && !bus.req_we[m_g1]) begin nv[m_g1] = 1; nb = 1; ndb = m_mem[rq_addr(m_g1)]; end
        if (m_g0 >= 0 && bus.req_we[m_g0]) m_mem[rq_addr(m_g0)] = rq_data(m_g0);
        if (m_g1 >= 0 && bus.req_we[m_g1]) m_mem[rq_addr(m_g1)] = rq_data(m_g1);
        if (m_conf && m_cnt < 255) m_cnt++;
        if (m_g1 >= 0)      m_ptr = (m_g1 + 1) % N;
        else if (m_g0 >= 0) m_ptr = (m_g0 + 1) % N;
        q2_v = q1_v; q2_a = q1_a; q2_b = q1_b; q2_da = q1_da; q2_db = q1_db;
        q1_v = nv;   q1_a = na;   q1_b = nb;   q1_da = nda;   q1_db = ndb;
    endtask

    task automatic step_begin();
        model_eval();
        #1;
    endtask

    task automatic step_end();
        model_commit();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, AW'(i), 8'hA0);
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready); end
        checks++; if ({ram_we_a, ram_we_b} !== 2'b00) begin errors++; $display("FAIL reset_ram_we got %b exp 00", {ram_we_a, ram_we_b}); end
        checks++; if (ram_addr_a !== 4'h0 || ram_din_a !== 8'h00) begin errors++; $display("FAIL reset_port_a got %h/%h exp 0/00", ram_addr_a, ram_din_a); end
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 8'h00 || bus.rsp_data_b !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h/%h exp 00/00", bus.rsp_data, bus.rsp_data_b); end
        checks++; if (conflict_cnt !== 8'h00) begin errors++; $display("FAIL reset_conflict_cnt got %0d exp 0", conflict_cnt); end
        do_reset();
    endtask

    task automatic test_write_read();
        do_reset();
        set_req(0, 1, 1, 4'd3, 8'h5A);
        step_begin();
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL wr_ready got %b exp 0001", bus.req_ready); end
        checks++; if ({ram_we_a, ram_addr_a, ram_din_a} !== {1'b1, 4'd3, 8'h5A}) begin errors++; $display("FAIL wr_port_a got %b/%h/%h exp 1/3/5a", ram_we_a, ram_addr_a, ram_din_a); end
        step_end();
        set_req(0, 0, 0, '0, '0);
        set_req(1, 1, 0, 4'd3, 8'h00);
        step_begin();
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rd_ready got %b exp 0010", bus.req_ready); end
        checks++; if (ram_we_a !== 1'b0 || ram_addr_a !== 4'd3) begin errors++; $display("FAIL rd_port_a got %b/%h exp 0/3", ram_we_a, ram_addr_a); end
        step_end();
        set_req(1, 0, 0, '0, '0);
        step_begin();
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rd_early_rsp got %b exp 0000", bus.rsp_valid); end
        step_end();
        step_begin();
        checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL rd_rsp_valid got %b exp 0010", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 8'h5A) begin errors++; $display("FAIL rd_rsp_data got %h exp 5a", bus.rsp_data); end
        step_end();
    endtask

    task automatic test_dual_read();
        do_reset();
        set_req(3, 1, 1, 4'd7, 8'h11);
        step_begin(); step_end();
        set_req(3, 0, 0, '0, '0);
        set_req(0, 1, 0, 4'd7, 8'h00);
        set_req(2, 1, 0, 4'd7, 8'h00);
        step_begin();
        checks++; if (bus.req_ready !== 4'b0101) begin errors++; $display("FAIL dual_ready got %b exp 0101", bus.req_ready); end
        checks++; if ({ram_we_b, ram_addr_b} !== {1'b0, 4'd7}) begin errors++; $display("FAIL dual_port_b got %b/%h exp 0/7", ram_we_b, ram_addr_b); end
        step_end();
        clear_all();
        step_begin(); step_end();
        step_begin();
        checks++; if (bus.rsp_valid !== 4'b0101) begin errors++; $display("FAIL dual_rsp_valid got %b exp 0101", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 8'h11 || bus.rsp_data_b !== 8'h11) begin errors++; $display("FAIL dual_rsp_data got %h/%h exp 11/11", bus.rsp_data, bus.rsp_data_b); end
        checks++; if (conflict_cnt !== 8'd0) begin errors++; $display("FAIL dual_conflict_cnt got %0d exp 0", conflict_cnt); end
        step_end();
    endtask

    task automatic test_conflict();
        do_reset();
        set_req(1, 1, 1, 4'd2, 8'hC3);
        set_req(3, 1, 0, 4'd2, 8'h00);
        step_begin();
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL conf_ready got %b exp 0010", bus.req_ready); end
        checks++; if (ram_we_b !== 1'b0) begin errors++; $display("FAIL conf_we_b got %b exp 0", ram_we_b); end
        step_end();
        set_req(1, 0, 0, '0, '0);
        step_begin();
        checks++; if (bus.req_ready !== 4'b1000 || ram_addr_a !== 4'd2) begin errors++; $display("FAIL conf_retry got %b/%h exp 1000/2", bus.req_ready, ram_addr_a); end
        checks++; if (conflict_cnt !== 8'd1) begin errors++; $display("FAIL conf_cnt got %0d exp 1", conflict_cnt); end
        step_end();
        clear_all();
        step_begin(); step_end();
        step_begin();
        checks++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 8'hC3) begin errors++; $display("FAIL conf_rsp got %b/%h exp 1000/c3", bus.rsp_valid, bus.rsp_data); end
        step_end();
    endtask

    task automatic test_all_busy();
        logic [N-1:0] exp;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(8 + i), 8'h00);
        for (int c = 0; c < 6; c++) begin
            exp = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            step_begin();
            checks++; if (bus.req_ready !== exp) begin errors++; $display("FAIL busy_ready c%0d got %b exp %b", c, bus.req_ready, exp); end
            if (c >= 2) begin
                checks++; if (bus.rsp_valid !== exp) begin errors++; $display("FAIL busy_rsp c%0d got %b exp %b", c, bus.rsp_valid, exp); end
            end
            step_end();
        end
        clear_all();
    endtask

    task automatic test_saturate();
        do_reset();
        set_req(0, 1, 1, 4'd5, 8'hAA);
        set_req(1, 1, 1, 4'd5, 8'h55);
        for (int c = 0; c < 300; c++) begin
            step_begin();
            if (c == 254 || c == 255 || c == 299) begin
                checks++; if (conflict_cnt !== 8'((c > 255) ? 255 : c)) begin errors++; $display("FAIL sat_cnt c%0d got %0d exp %0d", c, conflict_cnt, (c > 255) ? 255 : c); end
            end
            step_end();
        end
        clear_all();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        set_req(2, 1, 0, 4'd7, 8'h00);
        step_begin();
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL midrst_grant got %b exp 0100", bus.req_ready); end
        step_end();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(i), 8'h00);
        #1;
        checks++; if (bus.rsp_valid !== 4'b0000 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_outs got %b/%b exp 0000/0000", bus.rsp_valid, bus.req_ready); end
        checks++; if ({ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, conflict_cnt} !== 18'd0) begin errors++; $display("FAIL midrst_ram got %b%b/%h/%h/%0d exp 0", ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, conflict_cnt); end
        model_reset();
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step_begin();
            checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL midrst_rsp c%0d got %b exp 0000", c, bus.rsp_valid); end
            step_end();
        end
        for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(i), 8'h00);
        step_begin();
        checks++; if (bus.req_ready !== 4'b0011) begin errors++; $display("FAIL midrst_ptr got %b exp 0011", bus.req_ready); end
        step_end();
        clear_all();
    endtask

    task automatic test_random();
        bit           pend [N];
        logic [N-1:0] granted;
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 99) < 60) begin
                    pend[i] = 1;
                    set_req(i, 1, 1'($urandom_range(0, 1)),
                            AW'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15)),
                            DW'($urandom));
                end
            step_begin();
            checks++; if (bus.req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, bus.req_ready, e_ready); end
            checks++; if ({ram_we_a, ram_addr_a, ram_din_a} !== {e_we_a, e_addr_a, e_din_a}) begin errors++; $display("FAIL rnd_port_a c%0d got %b/%h/%h exp %b/%h/%h", c, ram_we_a, ram_addr_a, ram_din_a, e_we_a, e_addr_a, e_din_a); end
            checks++; if ({ram_we_b, ram_addr_b, ram_din_b} !== {e_we_b, e_addr_b, e_din_b}) begin errors++; $display("FAIL rnd_port_b c%0d got %b/%h/%h exp %b/%h/%h", c, ram_we_b, ram_addr_b, ram_din_b, e_we_b, e_addr_b, e_din_b); end
            checks++; if (bus.rsp_valid !== q2_v) begin errors++; $display("FAIL rnd_rsp_valid c%0d got %b exp %b", c, bus.rsp_valid, q2_v); end
            if (q2_a) begin
                checks++; if (bus.rsp_data !== q2_da) begin errors++; $display("FAIL rnd_rsp_data c%0d got %h exp %h", c, bus.rsp_data, q2_da); end
            end
            if (q2_b) begin
                checks++; if (bus.rsp_data_b !== q2_db) begin errors++; $display("FAIL rnd_rsp_data_b c%0d got %h exp %h", c, bus.rsp_data_b, q2_db); end
            end
            checks++; if (conflict_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_conflict_cnt c%0d got %0d exp %0d", c, conflict_cnt, m_cnt); end
            granted = e_ready;
            step_end();
            for (int i = 0; i < N; i++)
                if (granted[i]) begin
                    pend[i] = 0;
                    set_req(i, 0, 0, '0, '0);
                end
        end
        clear_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_dual_read();
        test_conflict();
        test_all_busy();
        test_saturate();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
